// File: rtl/cordic_pkg.sv
// Shared CORDIC types and constants: FSM state encoding, angle constants in
// fixed point (radians * 2^AFRAC) and the arctangent table generator.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_e;

  localparam int AFRAC_DEF = 24;

  function automatic real pow2_real(input int e);
    real r;
    r = 1.0;
    for (int k = 0; k < e; k++) r = r * 2.0;
    return r;
  endfunction

  // atan(2^-i) from its Taylor series; i = 0 is the exact pi/4.
  function automatic real atan_real(input int i);
    real t, term, acc;
    if (i == 0) return 0.78539816339744830962;
    t = 1.0 / pow2_real(i);
    acc = 0.0;
    term = t;
    for (int k = 0; k < 30; k++) begin
      acc = acc + (((k % 2) == 1) ? -1.0 : 1.0) * term / real'(2 * k + 1);
      term = term * t * t;
    end
    return acc;
  endfunction

  function automatic longint atan_lut(input int i, input int afrac);
    return longint'(atan_real(i) * pow2_real(afrac));
  endfunction

  function automatic longint half_pi_q(input int afrac);
    return longint'(1.57079632679489661923 * pow2_real(afrac));
  endfunction

  // 1/K = prod 1/sqrt(1 + 4^-i), inverse square roots by Newton iteration.
  function automatic longint cordic_k_q(input int afrac);
    real kinv, g, y;
    kinv = 1.0;
    for (int i = 0; i < 31; i++) begin
      g = 1.0 + 1.0 / pow2_real(2 * i);
      y = 1.0;
      for (int n = 0; n < 24; n++) y = y * (1.5 - 0.5 * g * y * y);
      kinv = kinv * y;
    end
    return longint'(kinv * pow2_real(afrac));
  endfunction

  localparam longint HALF_PI    = half_pi_q(AFRAC_DEF);
  localparam longint CORDIC_K_Q = cordic_k_q(AFRAC_DEF);

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: o_atan = round(atan(2^-i_idx) * 2^AFRAC).
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AFRAC = 24
) (
  input  logic [4:0]       i_idx,
  output logic [WIDTH-1:0] o_atan
);

  logic [WIDTH-1:0] w_tab [32];

  for (genvar k = 0; k < 32; k++) begin : g_entry
    localparam logic [WIDTH-1:0] ENTRY = WIDTH'(atan_lut(k, AFRAC));
    assign w_tab[k] = ENTRY;
  end

  assign o_atan = w_tab[i_idx];

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC, one micro-rotation per clock; vectoring or rotation chosen
// per transaction. Handshakes: a transfer happens on an edge where valid && ready.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 24,
  parameter int AFRAC = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic [1:0]       o_state
);

  localparam int XW = WIDTH + 2;
  localparam logic signed [WIDTH-1:0] HP = WIDTH'(half_pi_q(AFRAC));

  cordic_state_e r_state, w_next;
  logic                    r_mode;
  logic signed [XW-1:0]    r_x, r_y;
  logic signed [WIDTH-1:0] r_z;
  logic [4:0]              r_i;
  logic [WIDTH-1:0]        r_x_out, r_y_out, r_z_out;

  logic                    w_accept, w_last, w_d;
  logic [WIDTH-1:0]        w_atan;
  logic signed [WIDTH-1:0] w_z_in;
  logic signed [XW-1:0]    w_x_ext, w_y_ext, w_fx, w_fy, w_dx, w_dy, w_nx, w_ny;
  logic signed [WIDTH-1:0] w_fz, w_nz;

  cordic_atan_rom #(.WIDTH(WIDTH), .AFRAC(AFRAC)) u_rom (
    .i_idx  (r_i),
    .o_atan (w_atan)
  );

  function automatic logic [WIDTH-1:0] sat_w(input logic signed [XW-1:0] v);
    if ((&v[XW-1:WIDTH-1]) || !(|v[XW-1:WIDTH-1])) return v[WIDTH-1:0];
    else if (v[XW-1])                               return {1'b1, {(WIDTH-1){1'b0}}};
    else                                            return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_last    = (r_state == ST_ITER) && (r_i == 5'(ITER - 1));
  assign w_x_ext   = XW'($signed(x_in));
  assign w_y_ext   = XW'($signed(y_in));
  assign w_z_in    = $signed(z_in);
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign x_out     = r_x_out;
  assign y_out     = r_y_out;
  assign z_out     = r_z_out;
  assign o_state   = r_state;

  // Quadrant fold brings the start vector/angle into the +-pi/2 convergence range.
  always_comb begin
    w_fx = w_x_ext;
    w_fy = w_y_ext;
    w_fz = '0;
    if (!mode) begin
      if (x_in[WIDTH-1]) begin
        if (!y_in[WIDTH-1]) begin
          w_fx = w_y_ext;
          w_fy = -w_x_ext;
          w_fz = HP;
        end else begin
          w_fx = -w_y_ext;
          w_fy = w_x_ext;
          w_fz = -HP;
        end
      end
    end else begin
      w_fz = w_z_in;
      if (w_z_in > HP) begin
        w_fx = -w_y_ext;
        w_fy = w_x_ext;
        w_fz = w_z_in - HP;
      end else if (w_z_in < -HP) begin
        w_fx = w_y_ext;
        w_fy = -w_x_ext;
        w_fz = w_z_in + HP;
      end
    end
  end

  // w_d = 1 selects x += y>>>i, y -= x>>>i, z += atan_i.
  always_comb begin
    w_dx = r_y >>> r_i;
    w_dy = r_x >>> r_i;
    w_d  = r_mode ? r_z[WIDTH-1] : !r_y[XW-1];
    if (w_d) begin
      w_nx = r_x + w_dx;
      w_ny = r_y - w_dy;
      w_nz = r_z + $signed(w_atan);
    end else begin
      w_nx = r_x - w_dx;
      w_ny = r_y + w_dy;
      w_nz = r_z - $signed(w_atan);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_ITER;
      ST_ITER: if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_out <= '0;
    end else if (w_accept) begin
      r_mode <= mode;
      r_x    <= w_fx;
      r_y    <= w_fy;
      r_z    <= w_fz;
      r_i    <= '0;
    end else if (r_state == ST_ITER) begin
      r_x <= w_nx;
      r_y <= w_ny;
      r_z <= w_nz;
      r_i <= r_i + 5'd1;
      if (w_last) begin
        r_x_out <= sat_w(w_nx);
        r_y_out <= sat_w(w_ny);
        r_z_out <= w_nz;
      end
    end
  end

endmodule
